io_seg7_scan: RTL and testbench

- Memory-mapped output-port consumer for the single-cycle CPU's I/O space.
- Takes the 32-bit display value and 32-bit control word written to the output ports.
- Drives an 8-digit, common-anode, time-multiplexed 7-segment display.
- Port writes go to a shadow copy and are applied only at a scan-frame boundary, so the display never shows a half-updated value.

---
 rtl/io_seg7_scan.sv | 146 ++++++++++++++
 tb/tb_io_seg7_scan.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/io_seg7_scan.sv
// Eight-digit common-anode 7-segment scanner fed from the CPU output ports.
// Port writes land in a shadow copy and are applied only at the scan-frame wrap.
module io_seg7_scan #(
  parameter int unsigned SCAN_DIV = 50000,
  parameter logic [7:0]  EN_RST   = 8'hFF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] disp_value,
  input  logic [31:0] disp_ctrl,
  input  logic        load,
  output logic        upd_pending,
  output logic        frame_start,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int unsigned PW = $clog2(SCAN_DIV);
  localparam logic [PW-1:0] PS_MAX = PW'(SCAN_DIV - 1);

  logic [PW-1:0] r_presc;
  logic [2:0]    r_idx;

  logic [31:0]   r_val;
  logic [7:0]    r_dpm;
  logic [7:0]    r_en;
  logic          r_lz;

  logic [31:0]   r_sh_val;
  logic [7:0]    r_sh_dpm;
  logic [7:0]    r_sh_en;
  logic          r_sh_lz;

  logic          r_pend;
  logic          r_fs;
  logic [7:0]    r_an;
  logic [6:0]    r_seg;
  logic          r_dp;

  logic          w_tick;
  logic          w_wrap;
  logic [3:0]    w_nib;
  logic          w_hi_zero;
  logic          w_blank;
  logic [7:0]    w_an;
  logic [6:0]    w_seg;
  logic          w_dp;
  logic          w_unused_ctrl;

  assign w_unused_ctrl = ^disp_ctrl[31:17];

  assign w_tick = (r_presc == PS_MAX);
  assign w_wrap = w_tick && (r_idx == 3'd7);

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0:    hex7 = 7'h40;
      4'h1:    hex7 = 7'h79;
      4'h2:    hex7 = 7'h24;
      4'h3:    hex7 = 7'h30;
      4'h4:    hex7 = 7'h19;
      4'h5:    hex7 = 7'h12;
      4'h6:    hex7 = 7'h02;
      4'h7:    hex7 = 7'h78;
      4'h8:    hex7 = 7'h00;
      4'h9:    hex7 = 7'h10;
      4'hA:    hex7 = 7'h08;
      4'hB:    hex7 = 7'h03;
      4'hC:    hex7 = 7'h46;
      4'hD:    hex7 = 7'h21;
      4'hE:    hex7 = 7'h06;
      default: hex7 = 7'h0E;
    endcase
  endfunction

  // Leading-zero blank: this nibble and every more-significant one are zero.
  always_comb begin
    w_nib     = r_val[{r_idx, 2'b00} +: 4];
    w_hi_zero = ((r_val >> {r_idx, 2'b00}) == 32'd0);
    w_blank   = r_lz && (r_idx != 3'd0) && w_hi_zero;
    w_an      = 8'hFF;
    w_seg     = 7'h7F;
    w_dp      = 1'b1;
    if (r_en[r_idx]) begin
      w_an      = 8'hFF;
      w_an[r_idx] = 1'b0;
      w_dp      = ~r_dpm[r_idx];
      w_seg     = w_blank ? 7'h7F : hex7(w_nib);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_presc  <= '0;
      r_idx    <= '0;
      r_val    <= '0;
      r_dpm    <= '0;
      r_en     <= EN_RST;
      r_lz     <= 1'b0;
      r_sh_val <= '0;
      r_sh_dpm <= '0;
      r_sh_en  <= EN_RST;
      r_sh_lz  <= 1'b0;
      r_pend   <= 1'b0;
      r_fs     <= 1'b0;
      r_an     <= 8'hFE;
      r_seg    <= 7'h40;
      r_dp     <= 1'b1;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + 1'b1;
      if (w_tick) begin
        r_idx <= r_idx + 3'd1;
      end
      r_fs <= w_wrap;

      // Transfer reads the pre-edge shadow, so a coincident load is kept for the next frame.
      if (w_wrap && r_pend) begin
        r_val <= r_sh_val;
        r_dpm <= r_sh_dpm;
        r_en  <= r_sh_en;
        r_lz  <= r_sh_lz;
      end
      if (load) begin
        r_sh_val <= disp_value;
        r_sh_dpm <= disp_ctrl[7:0];
        r_sh_en  <= disp_ctrl[15:8];
        r_sh_lz  <= disp_ctrl[16];
        r_pend   <= 1'b1;
      end else if (w_wrap && r_pend) begin
        r_pend <= 1'b0;
      end

      r_an  <= w_an;
      r_seg <= w_seg;
      r_dp  <= w_dp;
    end
  end

  assign upd_pending = r_pend;
  assign frame_start = r_fs;
  assign an          = r_an;
  assign seg         = r_seg;
  assign dp          = r_dp;

endmodule

// File: tb/tb_io_seg7_scan.sv
// Scoreboard bench for io_seg7_scan: expectations are queued against a cycle
// number when stimulus is planned, and a negedge monitor retires them.
module tb_io_seg7_scan;

  localparam int SD = 4;
  localparam int R  = 3;   // cycle count at the last reset edge of the initial reset

  localparam int K_AN   = 0;
  localparam int K_SEG  = 1;
  localparam int K_DP   = 2;
  localparam int K_PEND = 3;
  localparam int K_FS   = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] disp_value = '0;
  logic [31:0] disp_ctrl  = '0;
  logic        load = 1'b0;
  logic        upd_pending;
  logic        frame_start;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;

  io_seg7_scan #(.SCAN_DIV(SD), .EN_RST(8'hFF)) dut (
    .clock       (clock),
    .reset       (reset),
    .disp_value  (disp_value),
    .disp_ctrl   (disp_ctrl),
    .load        (load),
    .upd_pending (upd_pending),
    .frame_start (frame_start),
    .an          (an),
    .seg         (seg),
    .dp          (dp)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    int         kind;
    logic [7:0] val;
    string      nm;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_err = 0;
  logic [7:0] mon_act;

  function automatic logic [7:0] actual(input int kind);
    case (kind)
      K_AN:    actual = an;
      K_SEG:   actual = {1'b0, seg};
      K_DP:    actual = {7'd0, dp};
      K_PEND:  actual = {7'd0, upd_pending};
      default: actual = {7'd0, frame_start};
    endcase
  endfunction

  function automatic logic [7:0] an_of(input int d);
    logic [7:0] a;
    a = 8'hFF;
    a[d] = 1'b0;
    return a;
  endfunction

  task automatic expect_at(input int t, input int kind, input logic [7:0] v, input string nm);
    exp_t e;
    e.cyc  = R + t;
    e.kind = kind;
    e.val  = v;
    e.nm   = $sformatf("%s@t%0d", nm, t);
    q.push_back(e);
  endtask

  task automatic expect_digit(input int frame, input int d, input logic [7:0] a,
                              input logic [6:0] s, input logic p, input string nm);
    int t;
    t = 32 * frame + 4 * d + 2;
    expect_at(t, K_AN,  a,          $sformatf("%s_d%0d_an", nm, d));
    expect_at(t, K_SEG, {1'b0, s},  $sformatf("%s_d%0d_seg", nm, d));
    expect_at(t, K_DP,  {7'd0, p},  $sformatf("%s_d%0d_dp", nm, d));
  endtask

  task automatic do_load(input int edge_t, input logic [31:0] v, input logic [31:0] c);
    while (cyc < R + edge_t - 1) @(negedge clock);
    disp_value = v;
    disp_ctrl  = c;
    load       = 1'b1;
    @(negedge clock);
    load       = 1'b0;
  endtask

  always @(negedge clock) begin
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].cyc <= cyc) begin
        mon_act = actual(q[i].kind);
        n_chk++;
        if (q[i].cyc < cyc) begin
          n_err++;
          $display("FAIL %s: sample slot passed (now cycle %0d)", q[i].nm, cyc);
        end else if (mon_act !== q[i].val) begin
          n_err++;
          $display("FAIL %s: got %h expected %h", q[i].nm, mon_act, q[i].val);
        end
        q.delete(i);
      end
    end
  end

  initial begin
    // Reset, then a blank scan of frame 0.
    expect_at(0, K_AN,   8'hFE, "rst_an");
    expect_at(0, K_SEG,  8'h40, "rst_seg");
    expect_at(0, K_DP,   8'h01, "rst_dp");
    expect_at(0, K_PEND, 8'h00, "rst_pend");
    expect_at(0, K_FS,   8'h00, "rst_fs");
    for (int d = 0; d < 8; d++) expect_digit(0, d, an_of(d), 7'h40, 1'b1, "scan0");
    expect_at(4,  K_AN, 8'hFE, "d0_last");
    expect_at(5,  K_AN, 8'hFD, "d1_first");
    expect_at(31, K_FS, 8'h00, "fs_before");
    expect_at(32, K_FS, 8'h01, "fs_wrap");
    expect_at(33, K_FS, 8'h00, "fs_after");
    expect_at(64, K_FS, 8'h01, "fs_wrap2");

    // Mid-frame load is held until the wrap.
    expect_at(39, K_PEND, 8'h00, "ld1_pend_pre");
    expect_at(40, K_PEND, 8'h01, "ld1_pend");
    expect_digit(1, 3, 8'hF7, 7'h40, 1'b1, "ld1_hold");
    expect_at(63, K_PEND, 8'h01, "ld1_pend_hold");
    expect_at(64, K_PEND, 8'h00, "ld1_pend_clr");
    expect_digit(2, 0, 8'hFE, 7'h21, 1'b0, "ld1");
    expect_digit(2, 1, 8'hFD, 7'h46, 1'b1, "ld1");
    expect_digit(2, 2, 8'hFB, 7'h03, 1'b1, "ld1");
    expect_digit(2, 3, 8'hF7, 7'h08, 1'b1, "ld1");
    expect_digit(2, 4, 8'hEF, 7'h19, 1'b1, "ld1");
    expect_digit(2, 7, 8'h7F, 7'h79, 1'b1, "ld1");
    reset = 1'b1;
    while (cyc < R) @(negedge clock);
    reset = 1'b0;
    do_load(40, 32'h1234ABCD, 32'h0000FF01);

    // Two loads in one frame: the second wins.
    for (int d = 0; d < 8; d++) expect_digit(3, d, an_of(d), 7'h24, 1'b1, "latest");
    expect_at(96, K_PEND, 8'h00, "latest_pend");
    do_load(70, 32'h11111111, 32'h0000FF00);
    do_load(80, 32'h22222222, 32'h0000FF00);

    // Leading-zero blanking keeps the anode driven.
    for (int d = 2; d < 8; d++) expect_digit(4, d, an_of(d), 7'h7F, 1'b1, "lz");
    expect_digit(4, 1, 8'hFD, 7'h08, 1'b1, "lz");
    expect_digit(4, 0, 8'hFE, 7'h40, 1'b1, "lz");
    do_load(100, 32'h000000A0, 32'h0001FF00);

    // Digit-enable mask turns off the upper four slots.
    expect_digit(5, 0, 8'hFE, 7'h79, 1'b1, "en");
    expect_digit(5, 1, 8'hFD, 7'h24, 1'b1, "en");
    expect_digit(5, 2, 8'hFB, 7'h30, 1'b1, "en");
    expect_digit(5, 3, 8'hF7, 7'h19, 1'b1, "en");
    for (int d = 4; d < 8; d++) expect_digit(5, d, 8'hFF, 7'h7F, 1'b1, "en");
    expect_at(160, K_PEND, 8'h00, "en_pend");
    do_load(140, 32'h87654321, 32'h00000F00);

    // Load coincident with the wrap, then reset with an update pending.
    expect_at(169, K_PEND, 8'h00, "wl_pend_pre");
    expect_at(192, K_PEND, 8'h01, "wl_pend_kept");
    expect_at(192, K_FS,   8'h01, "wl_fs");
    expect_digit(6, 0, 8'hFE, 7'h12, 1'b1, "wl_old");
    expect_digit(6, 1, 8'hFD, 7'h06, 1'b0, "wl_old");
    expect_digit(6, 2, 8'hFB, 7'h40, 1'b1, "wl_old");
    expect_at(200, K_PEND, 8'h01, "wl_pend_mid");
    expect_at(224, K_PEND, 8'h00, "wl_pend_clr");
    expect_digit(7, 0, 8'hFE, 7'h10, 1'b1, "wl_new");
    expect_digit(7, 1, 8'hFD, 7'h40, 1'b1, "wl_new");
    expect_at(236, K_PEND, 8'h01, "rp_pend_set");
    expect_at(239, K_PEND, 8'h01, "rp_pend_hold");
    expect_at(241, K_PEND, 8'h00, "rp_pend");
    expect_at(241, K_AN,   8'hFE, "rp_an");
    expect_at(241, K_SEG,  8'h40, "rp_seg");
    expect_at(241, K_DP,   8'h01, "rp_dp");
    expect_at(241, K_FS,   8'h00, "rp_fs");
    expect_at(271, K_AN,   8'h7F, "rp_d7_an");
    expect_at(271, K_SEG,  8'h40, "rp_d7_seg");
    expect_at(273, K_FS,   8'h01, "rp_fs_wrap");
    expect_at(275, K_AN,   8'hFE, "rp_post_an");
    expect_at(275, K_SEG,  8'h40, "rp_post_seg");
    expect_at(275, K_PEND, 8'h00, "rp_post_pend");
    do_load(170, 32'h000000E5, 32'h0000FF02);
    do_load(192, 32'h00000009, 32'h0000FF00);
    do_load(236, 32'hFFFFFFFF, 32'h0000FFFF);
    while (cyc < R + 239) @(negedge clock);
    reset = 1'b1;
    while (cyc < R + 241) @(negedge clock);
    reset = 1'b0;

    while (q.size() > 0 && cyc < R + 300) @(negedge clock);
    @(negedge clock);
    foreach (q[i]) begin
      n_chk++;
      n_err++;
      $display("FAIL %s: never sampled, expected %h", q[i].nm, q[i].val);
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
